alu_mc: RTL and testbench

// - Parametrised multi-cycle ALU for the MIPS core execute stage. Supersedes the single-cycle ALU.
// - Registered 1-cycle logic/add ops plus iterative shift-add multiply (and optional divide).
// - valid/ready handshake on both sides, so the pipeline stalls on in_ready / out_valid.

---
 rtl/alu_mc.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_alu_mc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc : multi-cycle ALU for the MIPS execute stage
//
// Purpose
//   Logic and add/subtract operations complete in one clock. Multiply uses
//   radix-2 shift-add with one partial product per clock. Divide is optional
//   and uses a restoring divider with one quotient bit per clock. Each
//   iterative operation takes DATA_WIDTH clocks after the accept edge. A
//   valid/ready handshake on both sides lets the pipeline stall on in_ready
//   and out_valid.
//
// Optional feature
//   ALU_DIV_EN : define to build DIVU/DIV. If it is not defined, op codes
//                1010 and 1011 are reserved, and no divider logic exists.
//
// Parameters
//   DATA_WIDTH : operand/result width (>= 8, even)
//   CNT_W      : iteration counter width, 2**CNT_W > DATA_WIDTH
//
// Ports
//   clk        in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  request can be accepted (IDLE only)
//   A, B       in   operands, captured at the accept edge
//   ALUop      in   operation code:
//                   0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT,
//                   0100 XOR, 0101 NOR, 0011 SLTU,
//                   1000 MULU, 1001 MUL, 1010 DIVU, 1011 DIV
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer takes the result
//   Result     out  result / low product / quotient
//   ResultHi   out  high product / remainder, 0 for single-cycle ops
//   Overflow   out  signed overflow (ADD/SUB only)
//   CarryOut   out  ADD carry / SUB borrow
//   Zero       out  Result == 0 ({ResultHi,Result} == 0 for multiplies)
// -----------------------------------------------------------------------------
module alu_mc #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_W      = 6
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic [3:0]            ALUop,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] Result,
   output logic [DATA_WIDTH-1:0] ResultHi,
   output logic                  Overflow,
   output logic                  CarryOut,
   output logic                  Zero
);

   localparam int W = DATA_WIDTH;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_NOR  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MULU = 4'b1000;
   localparam logic [3:0] OP_MUL  = 4'b1001;
`ifdef ALU_DIV_EN
   localparam logic [3:0] OP_DIVU = 4'b1010;
   localparam logic [3:0] OP_DIV  = 4'b1011;
`endif

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [W-1:0]     hi_reg;      // product high half / partial remainder
   logic [W-1:0]     lo_reg;      // multiplier / dividend, shifted to quotient
   logic [W-1:0]     opd_reg;     // multiplicand magnitude / divisor magnitude
   logic             neg_lo_reg;  // negate the product or quotient at the end
`ifdef ALU_DIV_EN
   logic             neg_hi_reg;  // negate the remainder at the end
   logic             div_reg;     // current iterative op is a divide
`endif

   assign in_ready = (state_reg == S_IDLE);

   // ---------------------------------------------------------------------
   // Single-cycle datapath. It works on the live inputs at the accept edge.
   // ---------------------------------------------------------------------
   logic         is_sub;
   logic [W-1:0] b_eff;
   logic [W:0]   sum_ext;
   logic         add_ovf;
   logic         borrow;
   logic [W-1:0] logic_res;
   logic [W-1:0] quick_res;
   logic         quick_ovf;
   logic         quick_cy;

   assign is_sub  = (ALUop == OP_SUB) || (ALUop == OP_SLT) || (ALUop == OP_SLTU);
   assign b_eff   = is_sub ? ~B : B;
   assign sum_ext = {1'b0, A} + {1'b0, b_eff} + {{W{1'b0}}, is_sub};
   // Comparing against the effective B sign covers both the ADD overflow
   // rule and the SUB overflow rule.
   assign add_ovf = (A[W-1] == b_eff[W-1]) && (sum_ext[W-1] != A[W-1]);
   assign borrow  = ~sum_ext[W];

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_logic
         assign logic_res[gi] =
            (ALUop[2:0] == 3'b000) ? (A[gi] & B[gi]) :
            (ALUop[2:0] == 3'b001) ? (A[gi] | B[gi]) :
            (ALUop[2:0] == 3'b100) ? (A[gi] ^ B[gi]) :
                                     ~(A[gi] | B[gi]);
      end
   endgenerate

   always_comb begin
      quick_res = '0;
      quick_ovf = 1'b0;
      quick_cy  = 1'b0;
      case (ALUop)
         OP_AND, OP_OR, OP_XOR, OP_NOR: quick_res = logic_res;
         OP_ADD: begin
            quick_res = sum_ext[W-1:0];
            quick_ovf = add_ovf;
            quick_cy  = sum_ext[W];
         end
         OP_SUB: begin
            quick_res = sum_ext[W-1:0];
            quick_ovf = add_ovf;
            quick_cy  = borrow;
         end
         OP_SLT:  quick_res = {{(W-1){1'b0}}, sum_ext[W-1] ^ add_ovf};
         OP_SLTU: quick_res = {{(W-1){1'b0}}, borrow};
         default: quick_res = '0;   // reserved: zero result, Zero flag set
      endcase
   end

   // ---------------------------------------------------------------------
   // Operand magnitudes. ALUop[0] marks the signed variants (MUL, DIV).
   // ---------------------------------------------------------------------
   logic         is_mul;
   logic         a_neg, b_neg;
   logic [W-1:0] a_mag, b_mag;

   assign is_mul = (ALUop == OP_MULU) || (ALUop == OP_MUL);
   assign a_neg  = ALUop[0] & A[W-1];
   assign b_neg  = ALUop[0] & B[W-1];
   assign a_mag  = a_neg ? -A : A;
   assign b_mag  = b_neg ? -B : B;

`ifdef ALU_DIV_EN
   logic is_div;
   assign is_div = (ALUop == OP_DIVU) || (ALUop == OP_DIV);
`endif

   // ---------------------------------------------------------------------
   // One iteration step. Multiply adds the multiplicand when the current
   // multiplier bit is set, then shifts {hi,lo} right. The carry enters hi.
   // ---------------------------------------------------------------------
   logic [W:0]   mul_sum;
   logic [W-1:0] hi_next;
   logic [W-1:0] lo_next;

`ifdef ALU_DIV_EN
   // Restoring divide: shift the next dividend bit into the remainder.
   // Subtract only when the divisor fits. The remainder stays below the
   // divisor, so a W-bit difference is exact whenever it is used.
   logic [W:0]   rem_sh;
   logic         div_fits;
   logic [W-1:0] div_diff;

   assign rem_sh   = {hi_reg, lo_reg[W-1]};
   assign div_fits = (rem_sh >= {1'b0, opd_reg});
   assign div_diff = rem_sh[W-1:0] - opd_reg;
`endif

   always_comb begin
      mul_sum = lo_reg[0] ? ({1'b0, hi_reg} + {1'b0, opd_reg}) : {1'b0, hi_reg};
      hi_next = mul_sum[W:1];
      lo_next = {mul_sum[0], lo_reg[W-1:1]};
`ifdef ALU_DIV_EN
      if (div_reg) begin
         hi_next = div_fits ? div_diff : rem_sh[W-1:0];
         lo_next = {lo_reg[W-2:0], div_fits};
      end
`endif
   end

   // Final-cycle sign fix-up on the value produced by the last step.
   logic [2*W-1:0] prod_full;
   logic [2*W-1:0] prod_fin;

   assign prod_full = {hi_next, lo_next};
   assign prod_fin  = neg_lo_reg ? -prod_full : prod_full;

`ifdef ALU_DIV_EN
   logic [W-1:0] quo_fin;
   logic [W-1:0] rem_fin;

   assign quo_fin = neg_lo_reg ? -lo_next : lo_next;
   assign rem_fin = neg_hi_reg ? -hi_next : hi_next;
`endif

   // ---------------------------------------------------------------------
   // Control FSM and registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
         opd_reg    <= '0;
         neg_lo_reg <= 1'b0;
`ifdef ALU_DIV_EN
         neg_hi_reg <= 1'b0;
         div_reg    <= 1'b0;
`endif
         out_valid  <= 1'b0;
         Result     <= '0;
         ResultHi   <= '0;
         Overflow   <= 1'b0;
         CarryOut   <= 1'b0;
         Zero       <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (in_valid) begin
                  if (is_mul) begin
                     hi_reg     <= '0;
                     lo_reg     <= b_mag;
                     opd_reg    <= a_mag;
                     neg_lo_reg <= a_neg ^ b_neg;
`ifdef ALU_DIV_EN
                     neg_hi_reg <= 1'b0;
                     div_reg    <= 1'b0;
`endif
                     cnt_reg    <= '0;
                     state_reg  <= S_CALC;
                  end
`ifdef ALU_DIV_EN
                  else if (is_div && (B == '0)) begin
                     // Divide by zero finishes at once with a fixed result.
                     Result    <= '1;
                     ResultHi  <= A;
                     Overflow  <= 1'b0;
                     CarryOut  <= 1'b0;
                     Zero      <= 1'b0;
                     out_valid <= 1'b1;
                     state_reg <= S_DONE;
                  end
                  else if (is_div) begin
                     hi_reg     <= '0;
                     lo_reg     <= a_mag;
                     opd_reg    <= b_mag;
                     neg_lo_reg <= a_neg ^ b_neg;
                     neg_hi_reg <= a_neg;
                     div_reg    <= 1'b1;
                     cnt_reg    <= '0;
                     state_reg  <= S_CALC;
                  end
`endif
                  else begin
                     Result    <= quick_res;
                     ResultHi  <= '0;
                     Overflow  <= quick_ovf;
                     CarryOut  <= quick_cy;
                     Zero      <= (quick_res == '0);
                     out_valid <= 1'b1;
                     state_reg <= S_DONE;
                  end
               end
            end

            S_CALC: begin
               hi_reg  <= hi_next;
               lo_reg  <= lo_next;
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == LAST_CNT) begin
                  cnt_reg   <= '0;
                  Overflow  <= 1'b0;
                  CarryOut  <= 1'b0;
                  out_valid <= 1'b1;
                  state_reg <= S_DONE;
`ifdef ALU_DIV_EN
                  if (div_reg) begin
                     Result   <= quo_fin;
                     ResultHi <= rem_fin;
                     Zero     <= (quo_fin == '0);
                  end else
`endif
                  begin
                     Result   <= prod_fin[W-1:0];
                     ResultHi <= prod_fin[2*W-1:W];
                     Zero     <= (prod_fin == '0);
                  end
               end
            end

            S_DONE: begin
               // Outputs hold until the consumer takes them.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_reg <= S_IDLE;
               end
            end

            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc : self-checking bench for alu_mc (DATA_WIDTH = 32)
//
// The bench runs these sequences:
//   - directed vectors from a table, each with its expected outputs and latency
//   - a held-result sequence with out_ready low for several cycles
//   - an asynchronous reset in the middle of a multiply
//   - random operations compared against an arithmetic reference model
// Define ALU_DIV_EN for both files when the divider is built.
// -----------------------------------------------------------------------------
module tb_alu_mc;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A, B;
   logic [3:0]  ALUop;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Result, ResultHi;
   logic        Overflow, CarryOut, Zero;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_mc #(.DATA_WIDTH(32), .CNT_W(6)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .A        (A),
      .B        (B),
      .ALUop    (ALUop),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .Result   (Result),
      .ResultHi (ResultHi),
      .Overflow (Overflow),
      .CarryOut (CarryOut),
      .Zero     (Zero)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [31:0] hi;
      logic        ovf;
      logic        cy;
      logic        zero;
      int          lat;
   } vec_t;

   function automatic void chk(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Reference model built from the arithmetic definitions.
   function automatic vec_t model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
      vec_t        v;
      longint      sa, sb, s, q, r;
      logic [63:0] p;
      bit          is_long;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      v.op = op; v.a = a; v.b = b;
      v.res = '0; v.hi = '0; v.ovf = 1'b0; v.cy = 1'b0; v.lat = 1;
      is_long = 1'b0;
      p = '0;
      case (op)
         4'b0000: v.res = a & b;
         4'b0001: v.res = a | b;
         4'b0100: v.res = a ^ b;
         4'b0101: v.res = ~(a | b);
         4'b0010: begin
            s = sa + sb;
            v.res = s[31:0];
            v.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            v.cy  = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
         end
         4'b0110: begin
            s = sa - sb;
            v.res = s[31:0];
            v.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            v.cy  = (a < b);
         end
         4'b0111: v.res = (sa < sb) ? 32'd1 : 32'd0;
         4'b0011: v.res = (a < b) ? 32'd1 : 32'd0;
         4'b1000: begin
            p = {32'd0, a} * {32'd0, b};
            v.res = p[31:0]; v.hi = p[63:32]; v.lat = 33; is_long = 1'b1;
         end
         4'b1001: begin
            s = sa * sb;
            p = s;
            v.res = p[31:0]; v.hi = p[63:32]; v.lat = 33; is_long = 1'b1;
         end
`ifdef ALU_DIV_EN
         4'b1010, 4'b1011: begin
            if (b == 32'd0) begin
               v.res = 32'hFFFF_FFFF; v.hi = a; v.lat = 1;
            end else if (op == 4'b1010) begin
               v.res = a / b; v.hi = a % b; v.lat = 33;
            end else begin
               q = sa / sb; r = sa % sb;
               v.res = q[31:0]; v.hi = r[31:0]; v.lat = 33;
            end
         end
`endif
         default: ;
      endcase
      v.zero = is_long ? (p == 64'd0) : (v.res == 32'd0);
      return v;
   endfunction

   task automatic run_op(input vec_t v, input int hold, input bit junk);
      int edges;
      bit got;
      @(negedge clk);
      chk("in_ready_idle", 64'(in_ready), 64'd1);
      A = v.a; B = v.b; ALUop = v.op; in_valid = 1'b1;
      edges = 0; got = 1'b0;
      while (!got && edges < 100) begin
         @(posedge clk); #1;
         edges++;
         if (junk) begin
            in_valid = 1'($urandom);
            A = $urandom; B = $urandom; ALUop = 4'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid) got = 1'b1;
         else chk("busy_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      if (!got) begin
         chk("timeout_out_valid", 64'(out_valid), 64'd1);
      end else begin
         chk("latency", 64'(edges), 64'(v.lat));
         chk("Result", 64'(Result), 64'(v.res));
         chk("ResultHi", 64'(ResultHi), 64'(v.hi));
         chk("Overflow", 64'(Overflow), 64'(v.ovf));
         chk("CarryOut", 64'(CarryOut), 64'(v.cy));
         chk("Zero", 64'(Zero), 64'(v.zero));
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("held_out_valid", 64'(out_valid), 64'd1);
            chk("held_result", {ResultHi, Result}, {v.hi, v.res});
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         chk("released_out_valid", 64'(out_valid), 64'd0);
         chk("released_in_ready", 64'(in_ready), 64'd1);
      end
      $display("op=%b A=%h B=%h -> Result=%h ResultHi=%h V=%b C=%b Z=%b lat=%0d",
               v.op, v.a, v.b, Result, ResultHi, Overflow, CarryOut, Zero, edges);
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   vec_t tbl[$];
   vec_t v;

   initial begin
      resetn = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; ALUop = '0;

      //        op       a             b             res           hi            V     C     Z     lat
      tbl.push_back('{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        1'b1, 1'b0, 1'b0, 1});
      tbl.push_back('{4'b0110, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b1, 1'b0, 1});
      tbl.push_back('{4'b0011, 32'h00000001, 32'h00000002, 32'h00000001, 32'h0,        1'b0, 1'b0, 1'b0, 1});
      tbl.push_back('{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0,        1'b0, 1'b0, 1'b0, 1});
      tbl.push_back('{4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0,        1'b0, 1'b0, 1'b0, 1});
      tbl.push_back('{4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 32'h0,        1'b0, 1'b0, 1'b0, 1});
      tbl.push_back('{4'b0101, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0, 1});
      tbl.push_back('{4'b0100, 32'h12345678, 32'h12345678, 32'h00000000, 32'h0,        1'b0, 1'b0, 1'b1, 1});
      tbl.push_back('{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        1'b0, 1'b1, 1'b1, 1});
      tbl.push_back('{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0,        1'b1, 1'b0, 1'b0, 1});
      tbl.push_back('{4'b1100, 32'h00000005, 32'h00000007, 32'h00000000, 32'h0,        1'b0, 1'b0, 1'b1, 1});
      tbl.push_back('{4'b1001, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0, 1'b0, 1'b0, 33});
      tbl.push_back('{4'b1000, 32'h00000000, 32'h12345678, 32'h00000000, 32'h0,        1'b0, 1'b0, 1'b1, 33});
`ifdef ALU_DIV_EN
      tbl.push_back('{4'b1011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33});
      tbl.push_back('{4'b1010, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000005, 1'b0, 1'b0, 1'b0, 1});
      tbl.push_back('{4'b1011, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 33});
      tbl.push_back('{4'b1010, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b0, 1'b0, 1'b0, 33});
`else
      tbl.push_back('{4'b1010, 32'h00000005, 32'h00000000, 32'h00000000, 32'h0,        1'b0, 1'b0, 1'b1, 1});
      tbl.push_back('{4'b1011, 32'hFFFFFFF9, 32'h00000002, 32'h00000000, 32'h0,        1'b0, 1'b0, 1'b1, 1});
`endif

      // Power-on reset
      #2 resetn = 1'b0;
      #1;
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_outputs", {ResultHi, Result}, 64'd0);
      chk("reset_flags", {61'd0, Overflow, CarryOut, Zero}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) resetn = 1'b1;

      // Directed table
      for (int i = 0; i < tbl.size(); i++) run_op(tbl[i], 0, 1'b0);

      // MUL with in_valid pulses while busy
      run_op('{4'b1001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 32'hFFFFFFFF,
               1'b0, 1'b0, 1'b0, 33}, 0, 1'b1);

      // MULU held with out_ready low for five cycles
      run_op('{4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE,
               1'b0, 1'b0, 1'b0, 33}, 5, 1'b0);

      // Asynchronous reset at cycle 10 of a MULU
      @(negedge clk);
      A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; ALUop = 4'b1000; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 resetn = 1'b0;
      #1;
      chk("midop_reset_in_ready", 64'(in_ready), 64'd1);
      chk("midop_reset_out_valid", 64'(out_valid), 64'd0);
      chk("midop_reset_outputs", {ResultHi, Result}, 64'd0);
      @(negedge clk) resetn = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (i % 10 == 0) chk("no_pulse_after_reset", 64'(out_valid), 64'd0);
      end
      run_op('{4'b0010, 32'h2, 32'h3, 32'h5, 32'h0, 1'b0, 1'b0, 1'b0, 1}, 0, 1'b0);

      // Random operations against the reference model
      for (int i = 0; i < 150; i++) begin
         v = model(4'($urandom_range(0, 15)), pick_val(), pick_val());
         run_op(v, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
